// File: rtl/adc_lane_merger_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_lane_merger_if                                                   |
// | Sample-input strobes and packed-word valid/ready output bus.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface adc_lane_merger_if #(
  parameter int NCH = 2,
  parameter int DW  = 16
);
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/adc_lane_merger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_lane_merger                                                      |
// | N-lane ADC sample aligner: per-lane FIFOs popped together into a     |
// | valid/ready output register, with overflow and skew status.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adc_lane_merger #(
  parameter int NCH      = 2,
  parameter int DW       = 16,
  parameter int DEPTH    = 16,
  parameter int SKEW_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             clr,
  adc_lane_merger_if.slave bus,
  output logic [NCH-1:0]   ovf_flag,
  output logic [15:0]      ovf_cnt,
  output logic             desync
);

  localparam int              c_aw       = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_full     = (c_aw+1)'(DEPTH);
  localparam logic [31:0]     c_skew_max = 32'(SKEW_MAX);

  logic [DW-1:0]     r_mem    [NCH][DEPTH];
  logic [c_aw-1:0]   r_wr_ptr [NCH];
  logic [c_aw-1:0]   r_rd_ptr [NCH];
  logic [c_aw:0]     r_level  [NCH];
  logic              r_out_valid;
  logic [NCH*DW-1:0] r_out_data;
  logic [NCH-1:0]    r_ovf_flag;
  logic [15:0]       r_ovf_cnt;
  logic              r_desync;

  logic [NCH-1:0]    w_lane_ready;
  logic [NCH-1:0]    w_push_req;
  logic [NCH-1:0]    w_push;
  logic [NCH-1:0]    w_pop;
  logic [NCH-1:0]    w_drop;
  logic              w_fire;
  logic              w_multi_en;
  logic              w_skew_bad;
  logic [c_aw:0]     w_max;
  logic [c_aw:0]     w_min;
  logic [NCH*DW-1:0] w_pack;

  always_comb begin
    w_lane_ready = '0;
    w_push_req   = '0;
    w_push       = '0;
    w_pop        = '0;
    w_drop       = '0;
    w_max        = '0;
    w_min        = c_full;
    w_pack       = '0;
    // Disabled lanes never block a fire and contribute zeros to the word.
    for (int i = 0; i < NCH; i++) begin
      w_lane_ready[i] = ~ch_en[i] | (r_level[i] != '0);
      w_push_req[i]   = bus.in_valid[i] & ch_en[i];
      if (ch_en[i]) begin
        if (r_level[i] > w_max) w_max = r_level[i];
        if (r_level[i] < w_min) w_min = r_level[i];
        w_pack[i*DW +: DW] = r_mem[i][r_rd_ptr[i]];
      end
    end
    w_fire = (ch_en != '0) & (&w_lane_ready) & (~r_out_valid | bus.out_ready);
    // A full lane still accepts a sample when it is being popped this cycle.
    for (int i = 0; i < NCH; i++) begin
      w_pop[i]  = w_fire & ch_en[i];
      w_push[i] = w_push_req[i] & ((r_level[i] != c_full) | w_pop[i]);
      w_drop[i] = w_push_req[i] & ~w_push[i];
    end
    w_multi_en = (ch_en & (ch_en - NCH'(1))) != '0;
    w_skew_bad = w_multi_en && (32'(w_max - w_min) > c_skew_max);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= bus.in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_level[i]  <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf_flag  <= '0;
      r_ovf_cnt   <= '0;
      r_desync    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!ch_en[i]) begin
          r_wr_ptr[i] <= '0;
          r_rd_ptr[i] <= '0;
          r_level[i]  <= '0;
        end else begin
          if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + c_aw'(1);
          if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + c_aw'(1);
          case ({w_push[i], w_pop[i]})
            2'b10:   r_level[i] <= r_level[i] + (c_aw+1)'(1);
            2'b01:   r_level[i] <= r_level[i] - (c_aw+1)'(1);
            default: r_level[i] <= r_level[i];
          endcase
        end
      end

      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pack;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Status events coinciding with clr survive the clear.
      if (clr) begin
        r_ovf_flag <= w_drop;
        r_ovf_cnt  <= {15'd0, |w_drop};
        r_desync   <= w_skew_bad;
      end else begin
        r_ovf_flag <= r_ovf_flag | w_drop;
        if ((|w_drop) && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
        r_desync   <= r_desync | w_skew_bad;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign ovf_flag      = r_ovf_flag;
  assign ovf_cnt       = r_ovf_cnt;
  assign desync        = r_desync;

endmodule
`default_nettype wire

// File: tb/tb_adc_lane_merger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_lane_merger                                                   |
// | Scoreboard bench for the 2-lane, 16-bit, depth-16 configuration.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_adc_lane_merger;

  localparam int NCH = 2;
  localparam int DW  = 16;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] ch_en;
  logic           clr;
  logic [NCH-1:0] ovf_flag;
  logic [15:0]    ovf_cnt;
  logic           desync;

  adc_lane_merger_if #(.NCH(NCH), .DW(DW)) bus ();

  adc_lane_merger #(.NCH(NCH), .DW(DW), .DEPTH(16), .SKEW_MAX(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .clr      (clr),
    .bus      (bus),
    .ovf_flag (ovf_flag),
    .ovf_cnt  (ovf_cnt),
    .desync   (desync)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pk(input logic [15:0] hi, input logic [15:0] lo);
    return {hi, lo};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      step();
      n++;
    end
    check(tag, 64'(n < 200), 64'd1);
  endtask

  // Every accepted output word is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("extra_word", 64'(exp_q.size()), 64'd1);
      else check("word", 64'(bus.out_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ch_en = '0; clr = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_ovf_flag",  64'(ovf_flag),      64'd0);
    check("rst_ovf_cnt",   64'(ovf_cnt),       64'd0);
    check("rst_desync",    64'(desync),        64'd0);

    // Latency: lane0 at c0, lane1 at c3 -> single word at c5.
    ch_en = 2'b11; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 2'b01; bus.in_data = pk(16'h0, 16'hA001);
    exp_q.push_back(pk(16'hB001, 16'hA001));
    step(); bus.in_valid = '0;
    step(); step();
    bus.in_valid = 2'b10; bus.in_data = pk(16'hB001, 16'h0);
    step(); bus.in_valid = '0;
    @(negedge clk) check("t1_c4_valid", 64'(bus.out_valid), 64'd0);
    step();
    @(negedge clk) check("t1_c5_valid", 64'(bus.out_valid), 64'd1);
    step();
    @(negedge clk) check("t1_c6_valid", 64'(bus.out_valid), 64'd0);

    // Overflow: 40 samples with no backpressure relief.
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.in_valid = 2'b11;
      bus.in_data  = pk(16'(16'h3000 + k), 16'(16'h2000 + k));
      if (k < 17) exp_q.push_back(pk(16'(16'h3000 + k), 16'(16'h2000 + k)));
      step();
    end
    bus.in_valid = '0;
    @(negedge clk);
    check("t2_ovf_flag", 64'(ovf_flag), 64'd3);
    check("t2_ovf_cnt",  64'(ovf_cnt),  64'd23);
    check("t2_desync",   64'(desync),   64'd0);
    step();
    bus.in_valid = 2'b01; bus.in_data = pk(16'h0, 16'h2FFF); clr = 1'b1;
    step();
    bus.in_valid = '0; clr = 1'b0;
    @(negedge clk);
    check("t2_clr_evt_cnt",  64'(ovf_cnt),  64'd1);
    check("t2_clr_evt_flag", 64'(ovf_flag), 64'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    check("t2_clr_cnt",  64'(ovf_cnt),  64'd0);
    check("t2_clr_flag", 64'(ovf_flag), 64'd0);
    step();
    bus.out_ready = 1'b1;
    wait_drain("t2_drain");

    // Full FIFO with simultaneous push and pop drops nothing.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (k == 17) bus.out_ready = 1'b1;
      bus.in_valid = 2'b11;
      bus.in_data  = pk(16'(16'h9000 + k), 16'(16'h8000 + k));
      exp_q.push_back(pk(16'(16'h9000 + k), 16'(16'h8000 + k)));
      step();
    end
    bus.in_valid = '0;
    @(negedge clk);
    check("t5_ovf_cnt",  64'(ovf_cnt),  64'd0);
    check("t5_ovf_flag", 64'(ovf_flag), 64'd0);
    step();
    wait_drain("t5_drain");

    // Lane1 holds stale samples, is disabled (flushed), then re-enabled.
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 2'b10; bus.in_data = pk(16'(16'hEE00 + k), 16'h0);
      step();
    end
    bus.in_valid = '0; ch_en = 2'b01;
    step();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 2'b11;
      bus.in_data  = pk(16'(16'h5000 + k), 16'(16'h4000 + k));
      exp_q.push_back(pk(16'h0, 16'(16'h4000 + k)));
      step();
    end
    bus.in_valid = '0;
    wait_drain("t3_drain_single");
    ch_en = 2'b11;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 2'b11;
      bus.in_data  = pk(16'(16'h7000 + k), 16'(16'h6000 + k));
      exp_q.push_back(pk(16'(16'h7000 + k), 16'(16'h6000 + k)));
      step();
    end
    bus.in_valid = '0;
    wait_drain("t3_drain_dual");

    // Skew: lane0 alone reaches level 9.
    for (int k = 0; k < 9; k++) begin
      bus.in_valid = 2'b01; bus.in_data = pk(16'h0, 16'(16'hC000 + k));
      step();
    end
    bus.in_valid = '0;
    @(negedge clk) check("t4_level9_pending", 64'(desync), 64'd0);
    step();
    @(negedge clk) check("t4_desync_set", 64'(desync), 64'd1);
    step();
    ch_en = 2'b10;
    step();
    @(negedge clk) check("t4_sticky", 64'(desync), 64'd1);
    step();
    ch_en = 2'b11; clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk) check("t4_clr", 64'(desync), 64'd0);

    // Asynchronous reset mid-burst.
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 2'b11;
      bus.in_data  = pk(16'(16'hD100 + k), 16'(16'hD000 + k));
      step();
    end
    bus.in_valid = '0;
    check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check("t6_async_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk) check("t6_out_data", 64'(bus.out_data), 64'd0);
    step();
    bus.out_ready = 1'b1;
    bus.in_valid = 2'b01; bus.in_data = pk(16'h0, 16'hF00D);
    step();
    bus.in_valid = '0;
    repeat (5) step();
    check("t6_no_word", 64'(bus.out_valid), 64'd0);
    check("t6_ovf_cnt", 64'(ovf_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
